// File: rtl/inert_intf.sv
// inert_intf: mode-3 16-bit SPI master plus the command sequencer that
// configures the inertial sensor and reads pitch rate / Z acceleration on
// every data-ready interrupt.
module inert_intf #(
    parameter int INIT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MISO,
    input  logic        INT,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld,
    output logic        init_done
);
    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FRONT, S_SHIFT, S_BACK} spi_state_t;
    typedef enum logic [2:0] {
        PWR_WAIT, WR_INT, WR_GYRO, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH
    } seq_state_t;

    // SPI engine state
    spi_state_t  spi_q, spi_d;
    logic [4:0]  div_q, div_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;      // only the second (data) byte survives
    logic [3:0]  bit_q, bit_d;
    logic        ss_n_q, ss_n_d;
    logic        done_now;

    // Sequencer state
    seq_state_t  seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;  // issue a start on the next clock
    logic        start_q, start_d;
    logic [7:0]  hold_pl_q, hold_pl_d, hold_ph_q, hold_ph_d, hold_al_q, hold_al_d;
    logic [15:0] ptch_q, ptch_d, az_q, az_d;
    logic        vld_q, vld_d, init_q, init_d;
    logic        int_s1_q, int_s2_q;
    logic [15:0] cmd;

    assign SS_n      = ss_n_q;
    assign SCLK      = div_q[4];
    assign MOSI      = tx_q[15];
    assign ptch_rt   = ptch_q;
    assign AZ        = az_q;
    assign vld       = vld_q;
    assign init_done = init_q;

    // Command word for whichever sequencer state is about to issue.
    always_comb begin
        cmd = 16'h0000;
        case (seq_q)
            WR_INT:  cmd = 16'h0D02;
            WR_GYRO: cmd = 16'h1150;
            RD_PL:   cmd = 16'hA200;
            RD_PH:   cmd = 16'hA300;
            RD_AL:   cmd = 16'hAC00;
            RD_AH:   cmd = 16'hAD00;
            default: cmd = 16'h0000;
        endcase
    end

    // SPI engine next state: divider drives SCLK, shift on falls, sample on rises.
    always_comb begin
        spi_d    = spi_q;
        div_d    = div_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        ss_n_d   = ss_n_q;
        done_now = 1'b0;
        case (spi_q)
            S_IDLE: begin
                if (start_q) begin
                    ss_n_d = 1'b0;
                    div_d  = 5'b10111;
                    tx_d   = cmd;
                    bit_d  = 4'd0;
                    spi_d  = S_FRONT;
                end
            end
            S_FRONT: begin
                // First SCLK fall carries no shift: MOSI already holds bit 15.
                div_d = div_q + 5'd1;
                if (div_q == 5'd31) spi_d = S_SHIFT;
            end
            S_SHIFT: begin
                div_d = div_q + 5'd1;
                if (div_q == 5'd31) tx_d = {tx_q[14:0], 1'b0};
                if (div_q == 5'd15) begin
                    rx_d  = {rx_q[6:0], MISO};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) spi_d = S_BACK;
                end
            end
            S_BACK: begin
                // SCLK stays high (div[4]=1) while the back porch runs out.
                div_d = div_q + 5'd1;
                if (div_q == 5'd30) begin
                    ss_n_d   = 1'b1;
                    done_now = 1'b1;
                    spi_d    = S_IDLE;
                end
            end
        endcase
    end

    // SPI engine registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_q  <= S_IDLE;
            div_q  <= 5'b11111;
            tx_q   <= 16'h0000;
            rx_q   <= 8'h00;
            bit_q  <= 4'd0;
            ss_n_q <= 1'b1;
        end else begin
            spi_q  <= spi_d;
            div_q  <= div_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            bit_q  <= bit_d;
            ss_n_q <= ss_n_d;
        end
    end

    // Two-flop synchroniser for the asynchronous data-ready line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
        end
    end

    // Sequencer next state: every issuing state waits one clock, then starts.
    always_comb begin
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        start_d   = 1'b0;
        hold_pl_d = hold_pl_q;
        hold_ph_d = hold_ph_q;
        hold_al_d = hold_al_q;
        ptch_d    = ptch_q;
        az_d      = az_q;
        vld_d     = 1'b0;
        init_d    = init_q;
        if (pend_q) begin
            start_d = 1'b1;
            pend_d  = 1'b0;
        end
        case (seq_q)
            PWR_WAIT: begin
                if (cnt_q == CW'(INIT_CYCLES - 1)) begin
                    seq_d  = WR_INT;
                    pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_INT: if (done_now) begin
                seq_d  = WR_GYRO;
                pend_d = 1'b1;
            end
            WR_GYRO: if (done_now) begin
                seq_d  = WAIT_INT;
                init_d = 1'b1;
            end
            WAIT_INT: if (int_s2_q) begin
                seq_d  = RD_PL;
                pend_d = 1'b1;
            end
            RD_PL: if (done_now) begin
                hold_pl_d = rx_q;
                seq_d     = RD_PH;
                pend_d    = 1'b1;
            end
            RD_PH: if (done_now) begin
                hold_ph_d = rx_q;
                seq_d     = RD_AL;
                pend_d    = 1'b1;
            end
            RD_AL: if (done_now) begin
                hold_al_d = rx_q;
                seq_d     = RD_AH;
                pend_d    = 1'b1;
            end
            RD_AH: if (done_now) begin
                // Both words update together so the consumer never sees a torn pair.
                ptch_d = {hold_ph_q, hold_pl_q};
                az_d   = {rx_q, hold_al_q};
                vld_d  = 1'b1;
                seq_d  = WAIT_INT;
            end
        endcase
    end

    // Sequencer registers and output holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q     <= PWR_WAIT;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            start_q   <= 1'b0;
            hold_pl_q <= 8'h00;
            hold_ph_q <= 8'h00;
            hold_al_q <= 8'h00;
            ptch_q    <= 16'h0000;
            az_q      <= 16'h0000;
            vld_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            start_q   <= start_d;
            hold_pl_q <= hold_pl_d;
            hold_ph_q <= hold_ph_d;
            hold_al_q <= hold_al_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            vld_q     <= vld_d;
            init_q    <= init_d;
        end
    end
endmodule

// File: tb/tb_inert_intf.sv
// tb_inert_intf: sensor model + transaction-level reference for inert_intf.
`timescale 1ns/1ps
module tb_inert_intf;
    localparam int INIT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MISO = 1'b0;
    logic        INT;
    logic        SS_n, SCLK, MOSI, vld, init_done;
    logic [15:0] ptch_rt, AZ;

    logic [7:0] int_set = 8'd0;   // bumped by stimulus to raise INT
    logic [7:0] int_ack = 8'd0;   // caught up by the sensor when 0x22 is read
    assign INT = (int_set != int_ack);

    inert_intf #(.INIT_CYCLES(INIT)) dut (
        .clk(clk), .rst(rst), .MISO(MISO), .INT(INT),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld), .init_done(init_done)
    );

    always #10 clk = ~clk;

    logic [7:0] reg_val [0:127];   // sensor register file, set by stimulus

    int checks = 0;
    int failures = 0;

    // Requests from the stimulus process, serviced by the checker.
    int          pin_seq = 0, pin_seen = 0;
    string       pin_name = "";
    logic [15:0] pin_ptch = 16'h0, pin_az = 16'h0;
    int          to_seq = 0, to_seen = 0;
    string       to_name = "";

    // Reference model state
    int          cyc = 0, fall_cyc = 0, rise_cyc = 0, since_rst = 0;
    int          rises = 0, exp_idx = 0;
    logic        in_x = 1'b0, prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
    logic        exp_init = 1'b0, exp_vld = 1'b0, int_at_vld = 1'b0;
    logic [15:0] word = 16'h0, exp_ptch = 16'h0, exp_az = 16'h0;
    logic [7:0]  rdata = 8'h0;
    logic [7:0]  sent [0:127];

    function automatic logic [15:0] exp_cmd(input int idx);
        if (idx == 0) return 16'h0D02;
        if (idx == 1) return 16'h1150;
        case ((idx - 2) % 4)
            0:       return 16'hA200;
            1:       return 16'hA300;
            2:       return 16'hAC00;
            default: return 16'hAD00;
        endcase
    endfunction

    function automatic int bpos(input int idx);
        return (idx < 2) ? -1 : (idx - 2) % 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s: got %0d required %0d..%0d at %0t", name, val, lo, hi, $time);
        end
    endtask

    // Sensor model and checker: one pass per clock, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        exp_vld = 1'b0;
        if (pin_seq != pin_seen) begin
            chk({pin_name, "_ptch_rt"}, 64'(ptch_rt), 64'(pin_ptch));
            chk({pin_name, "_AZ"}, 64'(AZ), 64'(pin_az));
            pin_seen = pin_seq;
        end
        if (to_seq != to_seen) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got no event required one within budget at %0t", to_name, $time);
            to_seen = to_seq;
        end
        if (rst) begin
            chk("reset_outputs", 64'({SS_n, SCLK, MOSI, vld, init_done, ptch_rt, AZ}),
                64'({5'b11000, 32'h0}));
            in_x = 1'b0; exp_idx = 0; exp_init = 1'b0;
            exp_ptch = 16'h0; exp_az = 16'h0; since_rst = 0; rises = 0;
            MISO = 1'b0;
        end else begin
            since_rst++;
            if (prev_ss && !SS_n) begin
                int gap;
                gap = cyc - rise_cyc;
                in_x = 1'b1; fall_cyc = cyc; rises = 0; word = 16'h0;
                MISO = 1'($urandom);
                if (exp_idx == 0)
                    chk_rng("init_delay", since_rst, INIT, INIT + 6);
                else if (bpos(exp_idx) == 0 && exp_idx > 2 && int_at_vld)
                    chk_rng("burst_restart_gap", gap, 2, 3);
                else if (exp_idx == 1 || bpos(exp_idx) > 0)
                    chk("ss_n_high_gap", 64'(gap), 64'(2));
            end
            if (in_x && !SS_n) begin
                if (prev_sclk && !SCLK) begin
                    if (rises == 0) chk("first_fall_time", 64'(cyc - fall_cyc), 64'(9));
                    MISO = (rises >= 8) ? rdata[3'(15 - rises)] : 1'($urandom);
                end
                if (!prev_sclk && SCLK) begin
                    chk("rise_time", 64'(cyc - fall_cyc), 64'(25 + 32 * rises));
                    word = {word[14:0], MOSI};
                    rises++;
                    if (rises == 8) begin
                        if (word[7]) begin
                            rdata = reg_val[word[6:0]];
                            sent[word[6:0]] = rdata;
                        end else begin
                            rdata = 8'($urandom);
                        end
                    end
                end
                if (!prev_ss && MOSI !== prev_mosi)
                    chk("mosi_change_on_fall", 64'({prev_sclk, SCLK}), 64'(2'b10));
            end
            if (in_x && !prev_ss && SS_n) begin
                in_x = 1'b0;
                rise_cyc = cyc;
                chk("ss_n_low_clks", 64'(cyc - fall_cyc), 64'(520));
                chk("sclk_rises", 64'(rises), 64'(16));
                chk($sformatf("mosi_word%0d", exp_idx), 64'(word), 64'(exp_cmd(exp_idx)));
                if (word == 16'hA200) int_ack = int_set;
                if (exp_idx == 1) exp_init = 1'b1;
                if (bpos(exp_idx) == 3) begin
                    exp_vld  = 1'b1;
                    exp_ptch = {sent[7'h23], sent[7'h22]};
                    exp_az   = {sent[7'h2D], sent[7'h2C]};
                    int_at_vld = (int_set != int_ack);
                end
                exp_idx++;
            end
            chk("vld", 64'(vld), 64'(exp_vld));
            chk("ptch_rt", 64'(ptch_rt), 64'(exp_ptch));
            chk("AZ", 64'(AZ), 64'(exp_az));
            chk("init_done", 64'(init_done), 64'(exp_init));
            if (SS_n) chk("sclk_idle_high", 64'(SCLK), 64'(1));
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        prev_mosi = MOSI;
    end

    task automatic raise_int();
        @(posedge clk); #2;
        int_set = int_set + 8'd1;
    endtask

    task automatic wait_vld(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (vld) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            to_name = name;
            to_seq++;
        end
    endtask

    task automatic wait_init(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge clk);
            if (init_done) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            to_name = name;
            to_seq++;
        end
    endtask

    task automatic pin(input string name, input logic [15:0] p, input logic [15:0] a);
        pin_name = name;
        pin_ptch = p;
        pin_az   = a;
        pin_seq++;
    endtask

    task automatic set_regs(input logic [15:0] p, input logic [15:0] a);
        reg_val[7'h22] = p[7:0];
        reg_val[7'h23] = p[15:8];
        reg_val[7'h2C] = a[7:0];
        reg_val[7'h2D] = a[15:8];
    endtask

    initial begin
        for (int i = 0; i < 128; i++) reg_val[i] = 8'($urandom);

        // Held reset: outputs pinned at reset values for 100 clocks.
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        wait_init("config");

        // Directed burst.
        set_regs(16'h03C2, 16'hFE80);
        raise_int();
        wait_vld("burst_03C2", 3000);
        pin("burst_03C2", 16'h03C2, 16'hFE80);

        // MISO capture with an alternating-bit pattern.
        set_regs(16'hA55A, 16'hC33C);
        raise_int();
        wait_vld("burst_5A", 3000);
        pin("burst_5A", 16'hA55A, 16'hC33C);

        // Back-to-back: INT re-raised while RD_AL is on the wire.
        set_regs(16'($urandom), 16'($urandom));
        raise_int();
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 3000 && !hit; k++) begin
                @(posedge clk);
                if (in_x && bpos(exp_idx) == 2) hit = 1'b1;
            end
            if (!hit) begin
                to_name = "reach_rd_al";
                to_seq++;
            end
        end
        #2 int_set = int_set + 8'd1;
        wait_vld("b2b_first", 3000);
        set_regs(16'($urandom), 16'($urandom));
        wait_vld("b2b_second", 3000);

        // Randomized bursts with random idle time before INT.
        for (int b = 0; b < 5; b++) begin
            set_regs(16'($urandom), 16'($urandom));
            repeat ($urandom_range(1, 40)) @(posedge clk);
            raise_int();
            wait_vld("random_burst", 3000);
        end

        // Reset during bit 9 of RD_PH.
        set_regs(16'($urandom), 16'($urandom));
        raise_int();
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 3000 && !hit; k++) begin
                @(posedge clk);
                if (in_x && bpos(exp_idx) == 1 && rises == 9) hit = 1'b1;
            end
            if (!hit) begin
                to_name = "reach_rd_ph_bit9";
                to_seq++;
            end
        end
        #2 rst = 1'b1;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        wait_init("reconfig");

        // Burst after re-configuration.
        set_regs(16'h1234, 16'hABCD);
        raise_int();
        wait_vld("burst_after_reset", 3000);
        pin("burst_after_reset", 16'h1234, 16'hABCD);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inert_intf.md
# inert_intf

Master-side interface to the six-axis inertial sensor: a 16-bit mode-3 SPI master plus a command sequencer that configures the sensor after reset and then, on every data-ready interrupt, reads the pitch-rate and Z-acceleration registers. It sits between the balance controller (consumer of `ptch_rt`, `AZ`, `vld`) and the sensor pins (`SS_n`, `SCLK`, `MOSI`, `MISO`, `INT`).

## Interface
- `INIT_CYCLES`, 65536, clocks to wait after reset before the first configuration write (bench overrides to 64).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `MISO`  in  1  serial data from sensor; may be Z when `SS_n`=1.
- `INT`  in  1  sensor data-ready, asynchronous; cleared by the sensor when reg 0x22 is read.
- `SS_n`  out  1  active-low slave select.
- `SCLK`  out  1  serial clock, `clk`/32, idles high.
- `MOSI`  out  1  serial data to sensor.
- `ptch_rt`  out  16  signed pitch rate {reg 0x23, reg 0x22}.
- `AZ`  out  16  signed Z acceleration {reg 0x2D, reg 0x2C}.
- `vld`  out  1  one-clock pulse: `ptch_rt`/`AZ` updated.
- `init_done`  out  1  high once both configuration writes completed.

## Operation
- Command word, MSB first: bit15 = R/Wn (1 read, 0 write), bits14:8 address, bits7:0 write data (don't-care, send 0x00, for reads). Read data is the second byte returned on MISO; first byte discarded.
- SPI engine states: IDLE, FRONT, SHIFT, BACK. 5-bit divider `div`; `SCLK` = `div[4]`.
  - Start (from sequencer, IDLE only): `SS_n`←0, `div`←5'b10111, 16-bit tx shift reg ← command, `MOSI` = tx[15].
  - First SCLK fall (`div` 11111→00000): no shift. Each subsequent fall: tx shifts left, `MOSI` = new tx[15].
  - Each SCLK rise (`div` 01111→10000): rx shift reg ← {rx[14:0], MISO}; bit counter +1.
  - After 16th rise: BACK; `SCLK` held high; when `div` reaches 11111, `SS_n`←1, engine `done` one clock, return to IDLE.
- Sequencer states: PWR_WAIT → WR_INT → WR_GYRO → WAIT_INT → RD_PL → RD_PH → RD_AL → RD_AH → WAIT_INT.
  - PWR_WAIT: count `INIT_CYCLES`, then issue.
  - WR_INT sends 0x0D02; WR_GYRO sends 0x1150; on its `done`, `init_done`←1.
  - WAIT_INT: `INT` double-flopped; when synced `INT`=1, go to RD_PL.
  - RD_PL 0xA200, RD_PH 0xA300, RD_AL 0xAC00, RD_AH 0xAD00; each captures rx[7:0] into the matching holding byte on `done`.
  - On RD_AH `done`: `ptch_rt` and `AZ` load both bytes simultaneously from holding regs (never torn), `vld`=1 for that clock.
- Each state issues its start 2 clocks after previous `done` (minimum `SS_n` high time 2 clk).
- `INT` is sampled only in WAIT_INT; assertions during a read burst are not lost because `INT` is level and stays high until the next 0x22 read.

## Timing
- Reset values: `SS_n`=1, `SCLK`=1, `MOSI`=0, `vld`=0, `init_done`=0, `ptch_rt`=0, `AZ`=0; sequencer in PWR_WAIT, counter 0.
- Relative to clock N where `SS_n` falls: first SCLK fall N+9, k-th rise N+25+32(k−1), 16th rise N+505, `SS_n` rises and `done` at N+520. Per-transaction `SS_n` low = 520 clk.
- MOSI changes only on SCLK fall edges; stable ≥16 clk around every rise.
- `INT` synced rise → `SS_n` fall of RD_PL: 3 clk. Last read `SS_n` rise → `vld`: same clock. Full burst ≈ 4×522 clk.
- `rst` mid-transaction: all outputs to reset values immediately (asynchronous), sequencer restarts from PWR_WAIT, `init_done`=0.
- `INT` already high at end of burst: next burst begins without returning low.

## Test plan
- Reset: assert `rst` → `SS_n`=1, `SCLK`=1, `vld`=0, `init_done`=0; hold 100 clk, no SCLK toggles.
- Config (`INIT_CYCLES`=64): release reset → after 64 clk two transactions, MOSI words 0x0D02 then 0x1150, `SS_n` low exactly 520 clk each, `init_done`=1 after second.
- Read burst with sensor model, ptch regs 0x23:0x22 = 0x03C2, AZ regs = 0xFE80: raise `INT` → MOSI 0xA200, 0xA300, 0xAC00, 0xAD00; one `vld` pulse with `ptch_rt`=0x03C2, `AZ`=0xFE80.
- Back-to-back: `INT` re-asserted during RD_AL → burst completes, second burst starts 2–3 clk after `vld`; `ptch_rt`/`AZ` change only on `vld`.
- Bit timing: check MOSI transitions only at SCLK falls and MISO captured at rises; send rx byte 0x5A → read correctly.
- Reset mid-burst (during RD_PH bit 9): `SS_n`→1 same clock, `vld` never pulses, configuration writes re-issued after `INIT_CYCLES`.
